conv_cfg_sequencer: RTL and testbench

- Initiator for conv_datapath. Receives a layer descriptor as a 32-bit valid/ready word stream from the host/DMA side.
- Assembles the descriptor into the wide configuration, bias and E_scale tile registers.
- Then issues the datapath start sequence: reset high for one cycle, followed by en high for one cycle.
- Holds all datapath inputs stable until the datapath reports done, then accepts the next descriptor.

---
 rtl/conv_cfg_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_conv_cfg_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_cfg_sequencer.sv
// conv_cfg_sequencer: loads a 135-word layer descriptor from a valid/ready
// word stream into the conv_datapath configuration and tile registers,
// sanity-checks it, then pulses dp_reset and dp_en. It then holds every
// datapath input steady until dp_done arrives.
module conv_cfg_sequencer #(
  parameter int WORD_W      = 32,
  parameter int BIAS_TILE_W = 1024,
  parameter int TAIL_TILE_W = 2048,
  parameter int RANK_TILE_W = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WORD_W-1:0]      s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   dp_done,
  output logic [3:0]             k,
  output logic [3:0]             s,
  output logic [3:0]             p,
  output logic [15:0]            of,
  output logic [15:0]            ox,
  output logic [15:0]            oy,
  output logic [15:0]            ix,
  output logic [15:0]            iy,
  output logic [15:0]            nif,
  output logic [15:0]            nif_in_2pow,
  output logic [15:0]            ix_in_2pow,
  output logic [15:0]            of_in_2pow,
  output logic [15:0]            ox_in_2pow,
  output logic [31:0]            nif_mult_k_mult_k,
  output logic                   mode,
  output logic [BIAS_TILE_W-1:0] bias_tile_val,
  output logic [TAIL_TILE_W-1:0] E_scale_tail_tile_val,
  output logic [RANK_TILE_W-1:0] E_scale_rank_tile_val,
  output logic                   dp_reset,
  output logic                   dp_en,
  output logic                   busy,
  output logic                   cfg_err
);

  localparam int BIAS_WORDS = BIAS_TILE_W / WORD_W;
  localparam int TAIL_WORDS = TAIL_TILE_W / WORD_W;
  localparam int RANK_WORDS = RANK_TILE_W / WORD_W;

  typedef enum logic [3:0] {
    ST_HDR, ST_CFG, ST_BIAS, ST_TAIL, ST_RANK, ST_CHK, ST_ARM, ST_FIRE, ST_RUN
  } state_t;

  state_t      state;
  logic [6:0]  cnt;
  logic        xfer;
  logic [31:0] kk_prod;

  // Words are only accepted while a descriptor is being loaded.
  assign s_ready = (state == ST_HDR) || (state == ST_CFG) || (state == ST_BIAS) ||
                   (state == ST_TAIL) || (state == ST_RANK);
  assign xfer    = s_valid && s_ready;

  // Reference product for the descriptor's precomputed nif*k*k field.
  assign kk_prod = 32'(nif) * 32'(k) * 32'(k);

  // Load sequencer, descriptor check and datapath start pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= ST_HDR;
      cnt                   <= '0;
      k                     <= '0;
      s                     <= '0;
      p                     <= '0;
      mode                  <= 1'b0;
      of                    <= '0;
      ox                    <= '0;
      oy                    <= '0;
      ix                    <= '0;
      iy                    <= '0;
      nif                   <= '0;
      nif_in_2pow           <= '0;
      ix_in_2pow            <= '0;
      of_in_2pow            <= '0;
      ox_in_2pow            <= '0;
      nif_mult_k_mult_k     <= '0;
      bias_tile_val         <= '0;
      E_scale_tail_tile_val <= '0;
      E_scale_rank_tile_val <= '0;
      dp_reset              <= 1'b0;
      dp_en                 <= 1'b0;
      busy                  <= 1'b0;
      cfg_err               <= 1'b0;
    end else begin
      case (state)
        ST_HDR: begin
          if (xfer) begin
            k       <= s_data[3:0];
            s       <= s_data[7:4];
            p       <= s_data[11:8];
            mode    <= s_data[12];
            cfg_err <= 1'b0;
            busy    <= 1'b1;
            cnt     <= '0;
            state   <= ST_CFG;
          end
        end
        ST_CFG: begin
          if (xfer) begin
            case (cnt[2:0])
              3'd0:    {ox, of}                 <= s_data[31:0];
              3'd1:    {ix, oy}                 <= s_data[31:0];
              3'd2:    {nif, iy}                <= s_data[31:0];
              3'd3:    {ix_in_2pow, nif_in_2pow} <= s_data[31:0];
              3'd4:    {ox_in_2pow, of_in_2pow}  <= s_data[31:0];
              default: nif_mult_k_mult_k        <= s_data[31:0];
            endcase
            if (cnt == 7'd5) begin
              cnt   <= '0;
              state <= ST_BIAS;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
        end
        ST_BIAS: begin
          if (xfer) begin
            bias_tile_val[int'(cnt[4:0])*WORD_W +: WORD_W] <= s_data;
            if (cnt == 7'(BIAS_WORDS - 1)) begin
              cnt   <= '0;
              state <= ST_TAIL;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
        end
        ST_TAIL: begin
          if (xfer) begin
            E_scale_tail_tile_val[int'(cnt[5:0])*WORD_W +: WORD_W] <= s_data;
            if (cnt == 7'(TAIL_WORDS - 1)) begin
              cnt   <= '0;
              state <= ST_RANK;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
        end
        ST_RANK: begin
          if (xfer) begin
            E_scale_rank_tile_val[int'(cnt[4:0])*WORD_W +: WORD_W] <= s_data;
            if (cnt == 7'(RANK_WORDS - 1)) begin
              cnt   <= '0;
              state <= ST_CHK;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
        end
        ST_CHK: begin
          if ((k == 4'd0) || (s == 4'd0) || (nif == 16'd0) || (nif_mult_k_mult_k != kk_prod)) begin
            cfg_err <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_HDR;
          end else begin
            dp_reset <= 1'b1;
            state    <= ST_ARM;
          end
        end
        ST_ARM: begin
          dp_reset <= 1'b0;
          dp_en    <= 1'b1;
          state    <= ST_FIRE;
        end
        ST_FIRE: begin
          dp_en <= 1'b0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (dp_done) begin
            busy  <= 1'b0;
            state <= ST_HDR;
          end
        end
        default: state <= ST_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_cfg_sequencer.sv
// Testbench for conv_cfg_sequencer: directed descriptors driven word by word;
// expected configurations are queued by the driver and checked by a monitor
// when the sequencer fires (dp_reset) or flags an error (cfg_err).
module tb_conv_cfg_sequencer;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          dp_done = 1'b0;
  logic [3:0]    k, s, p;
  logic [15:0]   of, ox, oy, ix, iy, nif;
  logic [15:0]   nif_in_2pow, ix_in_2pow, of_in_2pow, ox_in_2pow;
  logic [31:0]   nif_mult_k_mult_k;
  logic          mode;
  logic [1023:0] bias_tile_val;
  logic [2047:0] E_scale_tail_tile_val;
  logic [1023:0] E_scale_rank_tile_val;
  logic          dp_reset, dp_en, busy, cfg_err;

  conv_cfg_sequencer #(
    .WORD_W(32), .BIAS_TILE_W(1024), .TAIL_TILE_W(2048), .RANK_TILE_W(1024)
  ) dut (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dp_done(dp_done), .k(k), .s(s), .p(p), .of(of), .ox(ox), .oy(oy), .ix(ix), .iy(iy),
    .nif(nif), .nif_in_2pow(nif_in_2pow), .ix_in_2pow(ix_in_2pow), .of_in_2pow(of_in_2pow),
    .ox_in_2pow(ox_in_2pow), .nif_mult_k_mult_k(nif_mult_k_mult_k), .mode(mode),
    .bias_tile_val(bias_tile_val), .E_scale_tail_tile_val(E_scale_tail_tile_val),
    .E_scale_rank_tile_val(E_scale_rank_tile_val), .dp_reset(dp_reset), .dp_en(dp_en),
    .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    k, s, p;
    logic          mode;
    logic [18:0]   junk;
    logic [15:0]   of, ox, oy, ix, iy, nif, nif2, ix2, of2, ox2;
    logic [31:0]   nkk;
    logic [1023:0] bias;
    logic [2047:0] tail;
    logic [1023:0] rank;
    bit            bad;
    int            acc;
  } desc_t;

  desc_t   expq[$];
  int      cyc = 0;
  int      checks = 0;
  int      failures = 0;
  int      fired_cnt = 0;
  int      err_cnt = 0;
  int      exp_fires = 0;
  int      last_accept = 0;
  logic [2047:0] zero_t = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_tile(input string nm, input logic [2047:0] act, input logic [2047:0] exp,
                            input int nwords);
    int bad_w;
    bad_w = -1;
    for (int i = nwords - 1; i >= 0; i--)
      if (act[i*32 +: 32] !== exp[i*32 +: 32]) bad_w = i;
    checks++;
    if (bad_w >= 0) begin
      failures++;
      $display("FAIL %s: word %0d got %08h expected %08h", nm, bad_w,
               act[bad_w*32 +: 32], exp[bad_w*32 +: 32]);
    end
  endtask

  function automatic desc_t mk(input logic [3:0] k_, s_, p_, input logic mode_,
                               input logic [18:0] junk_, input logic [15:0] of_, ox_, oy_,
                               ix_, iy_, nif_, nif2_, ix2_, of2_, ox2_,
                               input logic [31:0] nkk_, seed, input bit bad_);
    desc_t d;
    d.k = k_; d.s = s_; d.p = p_; d.mode = mode_; d.junk = junk_;
    d.of = of_; d.ox = ox_; d.oy = oy_; d.ix = ix_; d.iy = iy_; d.nif = nif_;
    d.nif2 = nif2_; d.ix2 = ix2_; d.of2 = of2_; d.ox2 = ox2_; d.nkk = nkk_;
    d.bad = bad_; d.acc = 0;
    d.bias = '0; d.tail = '0; d.rank = '0;
    for (int i = 0; i < 32; i++) d.bias[i*32 +: 32] = seed ^ (i * 32'h01010101);
    for (int i = 0; i < 64; i++) d.tail[i*32 +: 32] = ~seed + i * 32'h9e3779b9;
    for (int i = 0; i < 32; i++) d.rank[i*32 +: 32] = {seed[15:0], seed[31:16]} - i * 32'h00130007;
    return d;
  endfunction

  function automatic logic [31:0] wd(input desc_t d, input int n);
    case (n)
      0: return {d.junk, d.mode, d.p, d.s, d.k};
      1: return {d.ox, d.of};
      2: return {d.ix, d.oy};
      3: return {d.nif, d.iy};
      4: return {d.ix2, d.nif2};
      5: return {d.ox2, d.of2};
      6: return d.nkk;
      default: begin
        if (n < 39) return d.bias[(n-7)*32 +: 32];
        else if (n < 103) return d.tail[(n-39)*32 +: 32];
        else return d.rank[(n-103)*32 +: 32];
      end
    endcase
  endfunction

  function automatic logic [204:0] exp_vec(input desc_t d);
    return {d.k, d.s, d.p, d.mode, d.of, d.ox, d.oy, d.ix, d.iy, d.nif,
            d.nif2, d.ix2, d.of2, d.ox2, d.nkk};
  endfunction

  function automatic logic [204:0] dut_vec();
    return {k, s, p, mode, of, ox, oy, ix, iy, nif,
            nif_in_2pow, ix_in_2pow, of_in_2pow, ox_in_2pow, nif_mult_k_mult_k};
  endfunction

  // Called just after a falling edge; returns just after the falling edge following the transfer.
  task automatic send_word(input logic [31:0] w, input bit stall);
    int g;
    if (stall) begin
      while ($urandom_range(0, 99) < 30) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
    end
    s_data  = w;
    s_valid = 1'b1;
    g = 0;
    while (!s_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!s_ready) check("s_ready_wait", s_ready, 1'b1);
    last_accept = cyc;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_desc(input desc_t d, input int first, input int last, input bit stall);
    desc_t e;
    for (int n = first; n <= last; n++) send_word(wd(d, n), stall);
    if (last == 134) begin
      e = d;
      e.acc = last_accept;
      expq.push_back(e);
    end
  endtask

  task automatic wait_fire();
    int g;
    g = 0;
    exp_fires++;
    while (fired_cnt < exp_fires && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("fire_wait", fired_cnt, exp_fires);
  endtask

  task automatic run_done(input int hold);
    bit rdy_seen;
    rdy_seen = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (s_ready) rdy_seen = 1'b1;
    end
    check("s_ready_low_in_run", rdy_seen, 1'b0);
    check("busy_in_run", busy, 1'b1);
    dp_done = 1'b1;
    @(negedge clk);
    dp_done = 1'b0;
    check("busy_drop_on_done", busy, 1'b0);
  endtask

  // Monitor: pops the queued expectation when the sequencer fires or flags an error.
  desc_t cur;
  desc_t tmp;
  bit    running = 1'b0, unstable = 1'b0, en_follow = 1'b0;
  logic  pr_reset = 1'b0, pr_en = 1'b0, pr_err = 1'b0;
  int    fire_cyc = 0;

  always @(negedge clk) begin
    if (en_follow) begin
      check("dp_en_width", dp_en, 1'b0);
      en_follow = 1'b0;
    end
    if (dp_reset && !pr_reset) begin
      check("pending_expectation", (expq.size() > 0), 1'b1);
      if (expq.size() > 0) begin
        cur = expq.pop_front();
        check("fired_good_desc", cur.bad, 1'b0);
        check("dp_reset_latency", cyc, cur.acc + 2);
        check("cfg_fields", dut_vec(), exp_vec(cur));
        check_tile("bias_tile", bias_tile_val, cur.bias, 32);
        check_tile("tail_tile", E_scale_tail_tile_val, cur.tail, 64);
        check_tile("rank_tile", E_scale_rank_tile_val, cur.rank, 32);
      end
      fire_cyc = cyc;
    end
    if (dp_en && !pr_en) begin
      check("dp_en_latency", cyc, fire_cyc + 1);
      check("dp_reset_width", dp_reset, 1'b0);
      en_follow = 1'b1;
      running   = 1'b1;
      unstable  = 1'b0;
      fired_cnt++;
    end
    if (running && ({dut_vec(), bias_tile_val, E_scale_tail_tile_val, E_scale_rank_tile_val} !==
                    {exp_vec(cur), cur.bias, cur.tail, cur.rank}))
      unstable = 1'b1;
    if (running && !busy) begin
      running = 1'b0;
      check("stable_through_run", unstable, 1'b0);
    end
    if (cfg_err && !pr_err) begin
      check("pending_expectation_err", (expq.size() > 0), 1'b1);
      if (expq.size() > 0) begin
        tmp = expq.pop_front();
        check("err_on_bad_desc", tmp.bad, 1'b1);
        check("cfg_err_latency", cyc, tmp.acc + 2);
      end
      err_cnt++;
    end
    pr_reset = dp_reset;
    pr_en    = dp_en;
    pr_err   = cfg_err;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    desc_t da, db, dc, dd, de, df, dg;
    da = mk(4'd3, 4'd2, 4'd1, 1'b1, 19'h0, 16'd64, 16'd64, 16'd3, 16'd256, 16'd256, 16'd1,
            16'd0, 16'd8, 16'd6, 16'd6, 32'd9, 32'ha6a6a5a5, 1'b0);
    db = mk(4'd1, 4'd1, 4'd0, 1'b0, 19'h7ffff, 16'd32, 16'd16, 16'd16, 16'd18, 16'd18, 16'd8,
            16'd3, 16'd5, 16'd5, 16'd4, 32'd8, 32'h5a5a0f0f, 1'b0);
    dc = mk(4'd3, 4'd1, 4'd1, 1'b0, 19'h0, 16'd8, 16'd8, 16'd8, 16'd10, 16'd10, 16'd1,
            16'd0, 16'd4, 16'd3, 16'd3, 32'd8, 32'h12345678, 1'b1);
    dd = mk(4'd5, 4'd1, 4'd2, 1'b0, 19'h0, 16'd16, 16'd28, 16'd28, 16'd32, 16'd32, 16'd4,
            16'd2, 16'd5, 16'd4, 16'd5, 32'd100, 32'hdeadbeef, 1'b0);
    de = mk(4'd3, 4'd1, 4'd1, 1'b1, 19'h0, 16'd128, 16'd14, 16'd14, 16'd16, 16'd16, 16'd16,
            16'd4, 16'd4, 16'd7, 16'd4, 32'd144, 32'hc0ffee00, 1'b0);
    df = mk(4'd7, 4'd2, 4'd3, 1'b0, 19'h1, 16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd3,
            16'd1, 16'd6, 16'd4, 16'd5, 32'd147, 32'h0badf00d, 1'b0);
    dg = mk(4'd2, 4'd2, 4'd0, 1'b1, 19'h2aaaa, 16'd256, 16'd7, 16'd7, 16'd14, 16'd14, 16'd300,
            16'd9, 16'd4, 16'd8, 16'd3, 32'd1200, 32'h600dcafe, 1'b0);

    // Reset state.
    #12;
    check("reset_outputs", {dut_vec(), dp_reset, dp_en, busy, cfg_err}, '0);
    check_tile("reset_bias", bias_tile_val, zero_t, 32);
    check_tile("reset_tail", E_scale_tail_tile_val, zero_t, 64);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("s_ready_in_hdr", s_ready, 1'b1);
    check("busy_idle", busy, 1'b0);

    // Nominal load; dp_done roughly 40 cycles after the last word.
    send_word(wd(da, 0), 1'b0);
    check("busy_after_w0", busy, 1'b1);
    send_desc(da, 1, 134, 1'b0);
    check("bias_first_word", bias_tile_val[31:0], 32'ha6a6a5a5);
    wait_fire();
    run_done(37);

    // Same flow with 30% s_valid stalls.
    send_desc(db, 0, 134, 1'b1);
    wait_fire();
    run_done(5);

    // Bad descriptor (nif*k*k mismatch), then a good one clears cfg_err.
    send_desc(dc, 0, 134, 1'b0);
    repeat (6) @(negedge clk);
    check("cfg_err_set", cfg_err, 1'b1);
    check("s_ready_after_err", s_ready, 1'b1);
    check("busy_after_err", busy, 1'b0);
    send_word(wd(dd, 0), 1'b0);
    check("cfg_err_cleared_by_w0", cfg_err, 1'b0);
    send_desc(dd, 1, 134, 1'b0);
    wait_fire();
    run_done(4);

    // Reset in the middle of the tail tile, then a full reload.
    send_desc(de, 0, 69, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("midload_reset_outputs", {dut_vec(), dp_reset, dp_en, busy, cfg_err}, '0);
    check_tile("midload_reset_bias", bias_tile_val, zero_t, 32);
    check_tile("midload_reset_tail", E_scale_tail_tile_val, zero_t, 64);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("s_ready_after_reset", s_ready, 1'b1);
    send_desc(de, 0, 134, 1'b1);
    wait_fire();
    run_done(3);

    // Stray dp_done during load; s_valid held in RUN; next W0 alongside dp_done.
    send_desc(df, 0, 20, 1'b0);
    dp_done = 1'b1;
    @(negedge clk);
    dp_done = 1'b0;
    check("busy_after_stray_done", busy, 1'b1);
    send_desc(df, 21, 134, 1'b0);
    wait_fire();
    s_data  = wd(dg, 0);
    s_valid = 1'b1;
    run_done(10);
    check("s_ready_after_done", s_ready, 1'b1);
    send_desc(dg, 0, 134, 1'b0);
    wait_fire();
    run_done(2);

    repeat (3) @(negedge clk);
    check("total_fires", fired_cnt, 6);
    check("total_errors", err_cnt, 1);
    check("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
